// File: rtl/speed_pkg.sv
// speed_pkg: shared state/winner types and LED pattern helpers for the speed round
package speed_pkg;
    localparam int MAX_W = 32;

    typedef enum logic [2:0] {IDLE, COUNT, SAMPLE, FLASH_ON, FLASH_OFF, FINISH} state_t;
    typedef enum logic [1:0] {WIN_LEFT, WIN_RIGHT, WIN_TIE} win_t;

    function automatic logic [MAX_W-1:0] therm(input int remaining, input int led_w);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) r[i] = (i < remaining) && (i < led_w);
        return r;
    endfunction

    // Right lights the low half, left the high half; the odd middle LED stays dark
    function automatic logic [MAX_W-1:0] win_pattern(input win_t code, input int led_w);
        logic [MAX_W-1:0] lo, hi;
        lo = therm(led_w / 2, led_w);
        hi = lo << (led_w - led_w / 2);
        return code == WIN_RIGHT ? lo : code == WIN_LEFT ? hi : lo | hi;
    endfunction
endpackage

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: maps registered FSM state, countdown and winner to the LED bar
module led_pattern_gen
    import speed_pkg::*;
#(
    parameter int LED_W = 7,
    parameter int RW = 3
)(
    input  state_t           state,
    input  logic [RW-1:0]    remaining,
    input  win_t             winner,
    output logic [LED_W-1:0] speed_led
);
    always_comb begin
        speed_led = state == COUNT    ? LED_W'(therm(int'(remaining), LED_W)) :
                    state == FLASH_ON ? LED_W'(win_pattern(winner, LED_W)) : '0;
    end
endmodule

// File: rtl/speed_round_seq.sv
// speed_round_seq: countdown, round-over pulse and winner flash for the speed round
module speed_round_seq
    import speed_pkg::*;
#(
    parameter int LED_W = 7,
    parameter int FLASHES = 4,
    localparam int FL_W = $clog2(FLASHES + 1)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             slowen,
    input  logic             slowen_fast,
    input  logic             slowen_slow,
    input  logic             speed_round,
    input  logic             abort,
    input  logic             speed_tie,
    input  logic             speed_right,
    output logic [LED_W-1:0] speed_led,
    output logic             winspeed,
    output logic             speed_exit,
    output logic             busy
);
    localparam int RW = $clog2(LED_W + 1);

    state_t state, next;
    logic [RW-1:0] remaining;
    logic [FL_W-1:0] flash_cnt;
    win_t winner;
    logic entry;

    always_comb begin
        next = state;
        if (abort) next = IDLE;
        else case (state)
            IDLE:      if (speed_round) next = COUNT;
            COUNT:     if (slowen && remaining <= RW'(1)) next = SAMPLE;
            SAMPLE:    if (slowen_slow) next = FLASH_ON;
            FLASH_ON:  if (slowen_fast) next = FLASH_OFF;
            FLASH_OFF: if (slowen_fast) next = flash_cnt == FL_W'(FLASHES) ? FINISH : FLASH_ON;
            FINISH:    if (slowen) next = IDLE;
            default:   next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            remaining <= '0;
            flash_cnt <= '0;
            winner <= WIN_LEFT;
            entry <= 1'b0;
        end else begin
            state <= next;
            entry <= state == COUNT && next == SAMPLE;
            if (abort) begin
                remaining <= '0;
                flash_cnt <= '0;
            end else begin
                if (state == IDLE && speed_round) remaining <= RW'(LED_W);
                if (state == COUNT && slowen && remaining > RW'(1)) remaining <= remaining - RW'(1);
                if (state == SAMPLE && slowen_slow) begin
                    winner <= speed_right ? WIN_RIGHT : speed_tie ? WIN_TIE : WIN_LEFT;
                    flash_cnt <= '0;
                end
                if (state == FLASH_ON && slowen_fast) flash_cnt <= flash_cnt + FL_W'(1);
            end
        end
    end

    led_pattern_gen #(.LED_W(LED_W), .RW(RW)) u_led (
        .state(state),
        .remaining(remaining),
        .winner(winner),
        .speed_led(speed_led)
    );

    assign winspeed = entry;
    assign speed_exit = state == FINISH;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_speed_round_seq.sv
// tb_speed_round_seq: randomized scenario bench for two parameterisations of speed_round_seq
module tb_speed_round_seq;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] slowen, slowen_fast, slowen_slow, speed_round, abort, speed_tie, speed_right;
    logic [6:0] led_a;
    logic [9:0] led_b;
    logic [1:0] winspeed, speed_exit, busy;
    int total = 0, bad = 0;
    int ws_cnt[2] = '{0, 0};
    int ex_cnt[2] = '{0, 0};

    always #5 clk = ~clk;

    speed_round_seq #(.LED_W(7), .FLASHES(3)) u_a (
        .clk(clk), .rst(rst), .slowen(slowen[0]), .slowen_fast(slowen_fast[0]),
        .slowen_slow(slowen_slow[0]), .speed_round(speed_round[0]), .abort(abort[0]),
        .speed_tie(speed_tie[0]), .speed_right(speed_right[0]), .speed_led(led_a),
        .winspeed(winspeed[0]), .speed_exit(speed_exit[0]), .busy(busy[0])
    );

    speed_round_seq #(.LED_W(10), .FLASHES(1)) u_b (
        .clk(clk), .rst(rst), .slowen(slowen[1]), .slowen_fast(slowen_fast[1]),
        .slowen_slow(slowen_slow[1]), .speed_round(speed_round[1]), .abort(abort[1]),
        .speed_tie(speed_tie[1]), .speed_right(speed_right[1]), .speed_led(led_b),
        .winspeed(winspeed[1]), .speed_exit(speed_exit[1]), .busy(busy[1])
    );

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (winspeed[i]) ws_cnt[i]++;
            if (speed_exit[i]) ex_cnt[i]++;
        end
    end

    function automatic int lw(int d); return d ? 10 : 7; endfunction
    function automatic int fl(int d); return d ? 1 : 3; endfunction
    function automatic logic [9:0] led(int d); return d ? led_b : {3'b000, led_a}; endfunction
    function automatic logic [9:0] therm_m(int k); return 10'((32'd1 << k) - 1); endfunction

    // Reference winner pattern: code 0 left, 1 right, 2 tie
    function automatic logic [9:0] pat_m(int d, int code);
        int w = lw(d), s = lw(d) / 2;
        logic [31:0] lo = (32'd1 << s) - 1;
        logic [31:0] hi = ((32'd1 << w) - 1) ^ ((32'd1 << (w - s)) - 1);
        return 10'(code == 1 ? lo : code == 0 ? hi : lo | hi);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with random ticks drawn only from mask {slow, fast, slowen}
    task automatic gap(int d, int n, logic [2:0] mask);
        repeat (n) begin
            slowen[d] = mask[0] & 1'($urandom);
            slowen_fast[d] = mask[1] & 1'($urandom);
            slowen_slow[d] = mask[2] & 1'($urandom);
            step();
        end
        slowen[d] = 0; slowen_fast[d] = 0; slowen_slow[d] = 0;
    endtask

    task automatic pulse(int d, int which);
        if (which == 0) slowen[d] = 1;
        if (which == 1) slowen_fast[d] = 1;
        if (which == 2) slowen_slow[d] = 1;
        step();
        slowen[d] = 0; slowen_fast[d] = 0; slowen_slow[d] = 0;
    endtask

    task automatic test_reset();
        speed_round[0] = 1; step(); speed_round[0] = 0;
        pulse(0, 0); pulse(0, 0);
        total++; if (led(0) !== therm_m(5)) begin bad++; $display("FAIL pre_reset_led got=%b exp=%b", led(0), therm_m(5)); end
        rst = 1; step();
        total++; if (busy[0] !== 1'b0 || led(0) !== 10'd0 || winspeed[0] !== 1'b0) begin bad++; $display("FAIL reset_first_cycle busy=%b led=%b ws=%b exp 0", busy[0], led(0), winspeed[0]); end
        step(); step(); rst = 0;
        total++; if (busy !== 2'b00 || speed_exit !== 2'b00 || winspeed !== 2'b00) begin bad++; $display("FAIL reset_outputs busy=%b exit=%b ws=%b exp 0", busy, speed_exit, winspeed); end
        gap(0, 3, 3'b111);
        total++; if (busy[0] !== 1'b0 || led(0) !== 10'd0) begin bad++; $display("FAIL reset_idle_stays busy=%b led=%b", busy[0], led(0)); end
    endtask

    task automatic test_countdown(int d, bit hold);
        int ws0 = ws_cnt[d];
        speed_round[d] = 1; slowen[d] = 1'($urandom); step();
        speed_round[d] = hold; slowen[d] = 0;
        for (int k = lw(d); k >= 1; k--) begin
            gap(d, $urandom_range(0, 2), 3'b110);
            total++; if (led(d) !== therm_m(k) || busy[d] !== 1'b1 || winspeed[d] !== 1'b0) begin bad++; $display("FAIL count d=%0d k=%0d led=%b exp=%b busy=%b ws=%b", d, k, led(d), therm_m(k), busy[d], winspeed[d]); end
            pulse(d, 0);
        end
        total++; if (led(d) !== 10'd0 || winspeed[d] !== 1'b1) begin bad++; $display("FAIL sample_entry d=%0d led=%b ws=%b exp led=0 ws=1", d, led(d), winspeed[d]); end
        gap(d, $urandom_range(1, 3), 3'b011);
        total++; if (winspeed[d] !== 1'b0 || ws_cnt[d] - ws0 != 1 || busy[d] !== 1'b1) begin bad++; $display("FAIL winspeed_once d=%0d ws=%b pulses=%0d exp 1", d, winspeed[d], ws_cnt[d] - ws0); end
    endtask

    task automatic test_flash(int d, int code, bit change);
        speed_right[d] = code == 1;
        speed_tie[d] = code == 2 || (code == 1 && 1'($urandom));
        pulse(d, 2);
        if (change) begin speed_right[d] = code != 1; speed_tie[d] = 1'($urandom); end
        for (int i = 1; i <= fl(d); i++) begin
            gap(d, $urandom_range(0, 2), 3'b101);
            total++; if (led(d) !== pat_m(d, code) || speed_exit[d] !== 1'b0) begin bad++; $display("FAIL flash_on d=%0d i=%0d led=%b exp=%b exit=%b", d, i, led(d), pat_m(d, code), speed_exit[d]); end
            pulse(d, 1);
            gap(d, $urandom_range(0, 2), 3'b101);
            total++; if (led(d) !== 10'd0 || speed_exit[d] !== 1'b0) begin bad++; $display("FAIL flash_off d=%0d i=%0d led=%b exit=%b", d, i, led(d), speed_exit[d]); end
            pulse(d, 1);
        end
        gap(d, $urandom_range(0, 3), 3'b110);
        total++; if (speed_exit[d] !== 1'b1 || led(d) !== 10'd0 || busy[d] !== 1'b1) begin bad++; $display("FAIL finish d=%0d exit=%b led=%b busy=%b", d, speed_exit[d], led(d), busy[d]); end
        pulse(d, 0);
        total++; if (speed_exit[d] !== 1'b0 || busy[d] !== 1'b0) begin bad++; $display("FAIL exit_to_idle d=%0d exit=%b busy=%b", d, speed_exit[d], busy[d]); end
        speed_right[d] = 0; speed_tie[d] = 0;
    endtask

    task automatic test_abort();
        int ws0, ex0;
        speed_round[0] = 1; step(); speed_round[0] = 0;
        repeat (lw(0)) pulse(0, 0);
        speed_right[0] = 1; pulse(0, 2); speed_right[0] = 0;
        pulse(0, 1);
        total++; if (led(0) !== 10'd0 || busy[0] !== 1'b1) begin bad++; $display("FAIL pre_abort_off led=%b busy=%b", led(0), busy[0]); end
        ws0 = ws_cnt[0]; ex0 = ex_cnt[0];
        abort[0] = 1; slowen_fast[0] = 1; step(); abort[0] = 0; slowen_fast[0] = 0;
        total++; if (busy[0] !== 1'b0 || led(0) !== 10'd0) begin bad++; $display("FAIL abort_flash_off busy=%b led=%b", busy[0], led(0)); end
        gap(0, 6, 3'b111);
        total++; if (ws_cnt[0] != ws0 || ex_cnt[0] != ex0 || busy[0] !== 1'b0) begin bad++; $display("FAIL abort_flash_quiet ws=%0d exit=%0d exp 0", ws_cnt[0] - ws0, ex_cnt[0] - ex0); end
        speed_round[0] = 1; step(); speed_round[0] = 0;
        repeat (lw(0) - 3) pulse(0, 0);
        total++; if (led(0) !== therm_m(3)) begin bad++; $display("FAIL pre_abort_count led=%b exp=%b", led(0), therm_m(3)); end
        ws0 = ws_cnt[0];
        abort[0] = 1; slowen[0] = 1; step(); abort[0] = 0; slowen[0] = 0;
        total++; if (busy[0] !== 1'b0 || led(0) !== 10'd0 || winspeed[0] !== 1'b0) begin bad++; $display("FAIL abort_count busy=%b led=%b ws=%b", busy[0], led(0), winspeed[0]); end
        gap(0, 8, 3'b111);
        total++; if (ws_cnt[0] != ws0 || busy[0] !== 1'b0) begin bad++; $display("FAIL abort_count_quiet ws=%0d busy=%b", ws_cnt[0] - ws0, busy[0]); end
    endtask

    task automatic test_back_to_back();
        speed_round[1] = 1;
        test_countdown(1, 1);
        test_flash(1, 0, 0);
        step();
        total++; if (busy[1] !== 1'b1 || led(1) !== therm_m(10)) begin bad++; $display("FAIL held_restart busy=%b led=%b exp=%b", busy[1], led(1), therm_m(10)); end
        speed_round[1] = 0;
        abort[1] = 1; step(); abort[1] = 0;
        total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL held_abort busy=%b", busy[1]); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int d = r % 2;
            test_countdown(d, 0);
            test_flash(d, $urandom_range(0, 2), 1'($urandom));
        end
    endtask

    initial begin
        rst = 1;
        {slowen, slowen_fast, slowen_slow, speed_round, abort, speed_tie, speed_right} = '0;
        repeat (3) step();
        rst = 0;
        test_reset();
        test_countdown(0, 0);
        test_flash(0, 1, 0);
        test_countdown(0, 0);
        test_flash(0, 2, 1);
        test_abort();
        test_countdown(1, 0);
        test_flash(1, 0, 1);
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
